// File: rtl/lsu_ctrl_if.sv
// Core-side request/response and data-memory bus of the load/store unit.
// slave = the LSU's view; master = the core plus memory that drive it.
interface lsu_ctrl_if;
    // core request
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    // core response
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        misaligned;
    logic        illegal;
    logic        bus_err;
    // data-memory bus
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  start, is_store, funct3, addr, store_data,
        output busy, done, load_data, misaligned, illegal, bus_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport master (
        output start, is_store, funct3, addr, store_data,
        input  busy, done, load_data, misaligned, illegal, bus_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: one word-aligned access per start, byte-lane steering,
// load extraction and a timeout that turns a stuck bus into bus_err.
module lsu_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  i_size,     // funct3[1:0]: 0 byte, 1 half, 2 word
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic        o_be,
    output logic [7:0]  o_byte
);
    localparam logic [1:0] LIDX = 2'(LANE);

    always_comb begin
        o_be   = 1'b0;
        o_byte = 8'h00;
        case (i_size)
            2'b00: begin
                o_be   = (i_addr_lo == LIDX);
                o_byte = i_wdata[7:0];
            end
            2'b01: begin
                o_be   = (i_addr_lo[1] == LIDX[1]);
                o_byte = LIDX[0] ? i_wdata[15:8] : i_wdata[7:0];
            end
            2'b10: begin
                o_be   = 1'b1;
                o_byte = i_wdata[8*LANE +: 8];
            end
            default: begin
                o_be   = 1'b0;
                o_byte = 8'h00;
            end
        endcase
    end
endmodule

module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus
);
    localparam int NUM_LANES = 4;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    typedef struct packed {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    state_t      r_state, w_next;
    lsu_req_t    r_req;
    logic [15:0] r_cnt;
    logic        r_mis, r_ill, r_err;
    logic [31:0] r_ld;

    logic        w_ill, w_mis, w_timeout, w_to_err, w_capture;
    logic [NUM_LANES-1:0]      w_be;
    logic [NUM_LANES-1:0][7:0] w_wbytes;

    function automatic logic [31:0] f_extract(input logic [2:0]  f3,
                                              input logic [1:0]  a,
                                              input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {a, 3'b000});
        h = 16'(w >> {a[1], 4'b0000});
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    // Decode is done on the live inputs so a rejected access never touches the bus.
    always_comb begin
        if (bus.is_store)
            w_ill = bus.funct3[2] || (bus.funct3[1:0] == 2'b11);
        else
            w_ill = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
        w_mis = !w_ill &&
                (((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                 ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00)));
    end

    assign w_timeout = (r_cnt == TO_LAST);

    // A load only completes on rvalid; a grant alone at the timeout is still an error.
    always_comb begin
        w_next    = r_state;
        w_to_err  = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start)
                    w_next = (w_ill || w_mis) ? S_DONE : S_REQ;
            end
            S_REQ: begin
                if (bus.mem_gnt && (r_req.is_store || bus.mem_rvalid)) begin
                    w_next    = S_DONE;
                    w_capture = !r_req.is_store;
                end else if (w_timeout) begin
                    w_next   = S_DONE;
                    w_to_err = 1'b1;
                end else if (bus.mem_gnt) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    w_next    = S_DONE;
                    w_capture = 1'b1;
                end else if (w_timeout) begin
                    w_next   = S_DONE;
                    w_to_err = 1'b1;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req <= '0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_req.is_store <= bus.is_store;
            r_req.funct3   <= bus.funct3;
            r_req.addr     <= bus.addr;
            r_req.wdata    <= bus.store_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_state == S_REQ || r_state == S_WAIT)
            r_cnt <= r_cnt + 16'd1;
        else
            r_cnt <= '0;
    end

    // Flags live only for the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mis <= 1'b0;
            r_ill <= 1'b0;
            r_err <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_mis <= 1'b0;
            r_ill <= 1'b0;
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_mis <= w_mis;
            r_ill <= w_ill;
        end else if (w_to_err) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_ld <= '0;
        else if (w_capture) r_ld <= f_extract(r_req.funct3, r_req.addr[1:0], bus.mem_rdata);
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        lsu_lane #(.LANE(gi)) u_lane (
            .i_size    (r_req.funct3[1:0]),
            .i_addr_lo (r_req.addr[1:0]),
            .i_wdata   (r_req.wdata),
            .o_be      (w_be[gi]),
            .o_byte    (w_wbytes[gi])
        );
    end

    logic w_in_req, w_wr;
    assign w_in_req = (r_state == S_REQ);
    assign w_wr     = w_in_req && r_req.is_store;

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.misaligned = r_mis;
    assign bus.illegal    = r_ill;
    assign bus.bus_err    = r_err;
    assign bus.load_data  = r_ld;
    assign bus.mem_req    = w_in_req;
    assign bus.mem_we     = w_wr;
    assign bus.mem_addr   = w_in_req ? {r_req.addr[31:2], 2'b00} : 32'h0;
    assign bus.mem_be     = w_wr ? w_be : 4'h0;
    assign bus.mem_wdata  = w_wr ? w_wbytes : 32'h0;
endmodule
